// File: rtl/mem_bist_pkg.sv
// Shared types and sizing for the scratch-RAM march-test initiator.
package mem_bist_pkg;

   localparam int unsigned DefAddrW = 4;
   localparam int unsigned DEPTH    = 2 ** DefAddrW;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRd,
      StWri,
      StRdi,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      PatChecker = 2'd0,
      PatAddr    = 2'd1,
      PatZero    = 2'd2,
      PatWalk    = 2'd3
   } pattern_e;

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 2 ** addr_w;
   endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Expected-data generator: (pattern, address, invert) -> byte. Used for both writes and compares.
module mem_bist_pattern
   import mem_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  pattern_e          sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic              invert,
   output logic [DATA_W-1:0] data
);

   logic [2*ADDR_W-1:0] addr_pair;
   logic [DATA_W-1:0]   pat;

   always_comb begin
      addr_pair = {~addr, addr};
      pat       = '0;
      unique case (sel)
         PatChecker: begin
            // 0x55 on even addresses, 0xAA on odd ones
            for (int unsigned i = 0; i < DATA_W; i++) begin
               pat[i] = ((i % 2) == 0) ^ addr[0];
            end
         end
         PatAddr: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
               pat[i] = addr_pair[i % (2 * ADDR_W)];
            end
         end
         PatZero: pat = '0;
         PatWalk: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
               pat[i] = ((32'(addr) % DATA_W) == i);
            end
         end
      endcase
      data = invert ? ~pat : pat;
   end

endmodule

// File: rtl/mem_bist_initiator.sv
// March-test initiator for the DFF scratch RAM: WR, RD, WRI, RDI phases with a one-cycle
// read pipeline, saturating error count and first-fail capture.
module mem_bist_initiator
   import mem_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        pattern_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ce_n,
   output logic              mem_lr_n,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_fail_addr
);

   localparam int unsigned       Depth    = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

   state_e              state_q;
   pattern_e            sel_q;
   pattern_e            pat_sel;
   logic                drain_q;
   logic [ADDR_W-1:0]   pat_addr;
   logic                pat_inv;
   logic [DATA_W-1:0]   pat_data;
   logic [DATA_W-1:0]   req_exp_q;
   logic [DATA_W-1:0]   cmp_exp_q;
   logic [ADDR_W-1:0]   cmp_addr_q;
   logic                cmp_valid_q;
   logic                cmp_hit;
   logic [CNT_W-1:0]    err_d;

   // Pattern is evaluated for the request that will be on the pins next cycle.
   always_comb begin
      pat_sel  = (state_q == StIdle) ? pattern_e'(pattern_sel) : sel_q;
      pat_addr = (state_q == StIdle || drain_q) ? '0 : mem_addr + ADDR_W'(1);
      pat_inv  = (state_q == StWri) || (state_q == StRdi) || (state_q == StRd && drain_q);
      cmp_hit  = cmp_valid_q && (mem_rdata != cmp_exp_q);
      err_d    = err_count;
      if (cmp_hit && err_count != '1) begin
         err_d = err_count + CNT_W'(1);
      end
   end

   mem_bist_pattern #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pattern (
      .sel    (pat_sel),
      .addr   (pat_addr),
      .invert (pat_inv),
      .data   (pat_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         sel_q           <= PatChecker;
         drain_q         <= 1'b0;
         req_exp_q       <= '0;
         cmp_exp_q       <= '0;
         cmp_addr_q      <= '0;
         cmp_valid_q     <= 1'b0;
         mem_addr        <= '0;
         mem_ce_n        <= 1'b1;
         mem_lr_n        <= 1'b1;
         mem_wdata       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_fail_addr <= '0;
      end else begin
         cmp_valid_q <= ~mem_ce_n;
         cmp_addr_q  <= mem_addr;
         cmp_exp_q   <= req_exp_q;
         err_count   <= err_d;
         if (cmp_hit && err_count == '0) begin
            first_fail_addr <= cmp_addr_q;
         end
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               mem_ce_n <= 1'b1;
               mem_lr_n <= 1'b1;
               if (start) begin
                  sel_q           <= pattern_e'(pattern_sel);
                  err_count       <= '0;
                  pass            <= 1'b0;
                  first_fail_addr <= '0;
                  state_q         <= StWr;
                  mem_addr        <= '0;
                  mem_lr_n        <= 1'b0;
                  mem_wdata       <= pat_data;
                  busy            <= 1'b1;
               end
            end
            StWr, StWri: begin
               mem_addr <= pat_addr;
               if (mem_addr == LastAddr) begin
                  state_q   <= (state_q == StWr) ? StRd : StRdi;
                  mem_lr_n  <= 1'b1;
                  mem_ce_n  <= 1'b0;
                  req_exp_q <= pat_data;
               end else begin
                  mem_wdata <= pat_data;
               end
            end
            StRd, StRdi: begin
               mem_addr <= pat_addr;
               if (drain_q) begin
                  drain_q <= 1'b0;
                  if (state_q == StRd) begin
                     state_q   <= StWri;
                     mem_lr_n  <= 1'b0;
                     mem_wdata <= pat_data;
                  end else begin
                     state_q <= StDone;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= (err_d == '0);
                  end
               end else if (mem_addr == LastAddr) begin
                  // Drain cycle: no request, last read data is compared
                  drain_q  <= 1'b1;
                  mem_ce_n <= 1'b1;
               end else begin
                  req_exp_q <= pat_data;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Self-checking bench: behavioural RAM with injectable faults, result and write scoreboards.
module tb_mem_bist_initiator;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    pattern_sel = 2'd0;
   logic [AW-1:0] mem_addr;
   logic          mem_ce_n;
   logic          mem_lr_n;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [5:0]    err_count;
   logic [AW-1:0] first_fail_addr;

   // Second instance with a 3-bit counter runs in lockstep off the same RAM read data
   logic [AW-1:0] s_mem_addr;
   logic          s_mem_ce_n;
   logic          s_mem_lr_n;
   logic [DW-1:0] s_mem_wdata;
   logic          s_busy;
   logic          s_done;
   logic          s_pass;
   logic [2:0]    s_err_count;
   logic [AW-1:0] s_first_fail_addr;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] ram [16];
   logic [7:0] stuck_mask = 8'h00;
   bit         cell_en = 1'b0;
   logic [3:0] cell_addr = 4'h0;

   typedef struct {
      logic       pass;
      logic [5:0] err;
      logic [2:0] sat;
      logic [3:0] ffa;
   } res_t;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   res_t res_q[$];
   wr_t  wr_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] read_fault(input logic [3:0] a, input logic [7:0] stored);
      if (cell_en && a == cell_addr) return 8'h00;
      return stored & ~stuck_mask;
   endfunction

   always @(posedge clk) begin
      if (!mem_lr_n) ram[mem_addr] <= mem_wdata;
      else if (!mem_ce_n) mem_rdata <= read_fault(mem_addr, ram[mem_addr]);
   end

   mem_bist_initiator #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .CNT_W  (6)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .pattern_sel     (pattern_sel),
      .mem_addr        (mem_addr),
      .mem_ce_n        (mem_ce_n),
      .mem_lr_n        (mem_lr_n),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_fail_addr (first_fail_addr)
   );

   mem_bist_initiator #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .CNT_W  (3)
   ) dut_sat (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .pattern_sel     (pattern_sel),
      .mem_addr        (s_mem_addr),
      .mem_ce_n        (s_mem_ce_n),
      .mem_lr_n        (s_mem_lr_n),
      .mem_wdata       (s_mem_wdata),
      .mem_rdata       (mem_rdata),
      .busy            (s_busy),
      .done            (s_done),
      .pass            (s_pass),
      .err_count       (s_err_count),
      .first_fail_addr (s_first_fail_addr)
   );

   function automatic logic [7:0] pat_model(input logic [1:0] sel, input logic [3:0] a,
                                            input bit inv);
      logic [7:0] p;
      case (sel)
         2'd0:    p = a[0] ? 8'hAA : 8'h55;
         2'd1:    p = {~a, a};
         2'd2:    p = 8'h00;
         default: p = 8'h01 << a[2:0];
      endcase
      return inv ? ~p : p;
   endfunction

   task automatic push_expected(input logic [1:0] sel);
      int   err = 0;
      bit   first = 1'b1;
      res_t r;
      logic [7:0] e;
      r.ffa = 4'h0;
      for (int inv = 0; inv < 2; inv++) begin
         for (int a = 0; a < 16; a++) begin
            e = pat_model(sel, 4'(a), inv[0]);
            if (read_fault(4'(a), e) !== e) begin
               err++;
               if (first) r.ffa = 4'(a);
               first = 1'b0;
            end
         end
      end
      r.pass = (err == 0);
      r.err  = (err > 63) ? 6'd63 : 6'(err);
      r.sat  = (err > 7) ? 3'd7 : 3'(err);
      res_q.push_back(r);
   endtask

   // One full run; checks result at done, done timing, busy length, single done pulse.
   task automatic run_once(input logic [1:0] sel, input bit rd_pulse);
      int   t0;
      int   busy_cnt = 0;
      int   done_cnt = 0;
      int   done_t = -1;
      res_t r;
      wr_t  w;
      @(negedge clk);
      pattern_sel = sel;
      start = 1'b1;
      push_expected(sel);
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rd_pulse) start = ((cyc - t0) == 20);
         if (busy === 1'b1) busy_cnt++;
         if (mem_lr_n === 1'b0 && wr_q.size() > 0) begin
            w = wr_q.pop_front();
            checks++;
            if (mem_addr !== w.a || mem_wdata !== w.d) begin
               failures++;
               $display("FAIL write_pin: got addr=%0h data=%0h expected addr=%0h data=%0h",
                        mem_addr, mem_wdata, w.a, w.d);
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1 && res_q.size() > 0) begin
               done_t = cyc - t0;
               r = res_q.pop_front();
               checks++;
               if (pass !== r.pass) begin
                  failures++;
                  $display("FAIL pass: got %0b expected %0b", pass, r.pass);
               end
               checks++;
               if (err_count !== r.err) begin
                  failures++;
                  $display("FAIL err_count: got %0d expected %0d", err_count, r.err);
               end
               checks++;
               if (first_fail_addr !== r.ffa) begin
                  failures++;
                  $display("FAIL first_fail_addr: got %0d expected %0d", first_fail_addr, r.ffa);
               end
               checks++;
               if (s_err_count !== r.sat) begin
                  failures++;
                  $display("FAIL err_count_sat: got %0d expected %0d", s_err_count, r.sat);
               end
            end
         end
      end
      start = 1'b0;
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL done_pulses: got %0d expected 1", done_cnt);
      end
      checks++;
      if (done_t != 66) begin
         failures++;
         $display("FAIL done_latency: got %0d expected 66", done_t);
      end
      checks++;
      if (busy_cnt != 66) begin
         failures++;
         $display("FAIL busy_cycles: got %0d expected 66", busy_cnt);
      end
      checks++;
      if (wr_q.size() != 0) begin
         failures++;
         $display("FAIL write_trace: got %0d unmatched expected 0", wr_q.size());
      end
      res_q.delete();
      wr_q.delete();
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if ({mem_addr, mem_ce_n, mem_lr_n, mem_wdata, busy, done, pass, err_count, first_fail_addr}
          !== {4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 4'h0}) begin
         failures++;
         $display("FAIL %s: got addr=%0h ce_n=%0b lr_n=%0b wd=%0h busy=%0b done=%0b pass=%0b err=%0d ffa=%0h expected all reset values",
                  name, mem_addr, mem_ce_n, mem_lr_n, mem_wdata, busy, done, pass, err_count,
                  first_fail_addr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset_state");
      checks++;
      if (s_err_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_sat_err: got %0d expected 0", s_err_count);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_checkerboard();
      wr_q.push_back('{a: 4'h0, d: 8'h55});
      wr_q.push_back('{a: 4'h1, d: 8'hAA});
      run_once(2'd0, 1'b0);
   endtask

   task automatic test_stuck_bit();
      stuck_mask = 8'h08;
      run_once(2'd2, 1'b0);
      stuck_mask = 8'h00;
   endtask

   task automatic test_cell_fault();
      cell_en = 1'b1;
      cell_addr = 4'd9;
      run_once(2'd1, 1'b0);
      cell_en = 1'b0;
   endtask

   task automatic test_walk_ignore_start();
      for (int a = 0; a < 9; a++) begin
         wr_q.push_back('{a: 4'(a), d: 8'h01 << (a % 8)});
      end
      run_once(2'd3, 1'b1);
   endtask

   task automatic test_rst_mid_run();
      bit found = 1'b0;
      @(negedge clk);
      pattern_sel = 2'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (mem_lr_n === 1'b0 && mem_addr === 4'd5) begin
            found = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rst_mid_reach: got no write to addr 5 expected one within 30 cycles");
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (mem_lr_n !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_lr_n: got %0b expected 1", mem_lr_n);
      end
      check_reset_values("rst_mid_values");
      @(negedge clk);
      rst = 1'b0;
      run_once(2'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_checkerboard();
      test_stuck_bit();
      test_cell_fault();
      test_walk_ignore_start();
      test_rst_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
